// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the DDR3 read/write arbiter: FSM states, grant owner,
// and burst byte-size arithmetic.
package ddr_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_BUSY = 3'd2,
        RD_REQ  = 3'd3,
        RD_BUSY = 3'd4
    } arb_state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    // Bytes moved by one burst of (len+1) beats of beat_bytes each.
    function automatic logic [31:0] burst_bytes(input logic [15:0] len,
                                                input logic [31:0] beat_bytes);
        return (32'(len) + 32'd1) * beat_bytes;
    endfunction

endpackage

// File: rtl/ddr_addr_gen.sv
// Burst start-address pointer for one side: walks [beg_addr, end_addr] in whole bursts,
// wraps to beg_addr when the next burst would not fit, and can be held at beg_addr.
module ddr_addr_gen
    import ddr_arb_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 30,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      idle,
    input  logic                      clr,
    input  logic                      advance,
    input  logic [AXI_ADDR_WIDTH-1:0] beg_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] end_addr,
    input  logic [LEN_WIDTH-1:0]      len,
    output logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic                      wrap
);

    localparam int          AW1        = AXI_ADDR_WIDTH + 1;
    localparam logic [31:0] BEAT_BYTES = 32'(AXI_DATA_WIDTH / 8);

    logic [AW1-1:0] bytes;
    logic [AW1-1:0] nxt;
    logic [AW1-1:0] nxt_last;

    assign bytes    = AW1'(burst_bytes(16'(len), BEAT_BYTES));
    assign nxt      = {1'b0, addr} + bytes;
    assign nxt_last = nxt + bytes - AW1'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= beg_addr;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (advance) begin
                // A clear that arrived mid-burst lands here: restart silently, no wrap pulse.
                if (clr) begin
                    addr <= beg_addr;
                end else if (nxt_last > {1'b0, end_addr}) begin
                    addr <= beg_addr;
                    wrap <= 1'b1;
                end else begin
                    addr <= nxt[AXI_ADDR_WIDTH-1:0];
                end
            end else if (clr && idle) begin
                addr <= beg_addr;
            end
        end
    end

endmodule

// File: rtl/ddr_rw_arbiter.sv
// Shares one DDR3 AXI master between the write-FIFO ingest path and the read-FIFO fetch
// path: round-robin burst grants, per-side address windows with wrap-around.
module ddr_rw_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 30,
    parameter int LEN_WIDTH      = 8,
    parameter int CNT_WIDTH      = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      calib_done,
    input  logic [AXI_ADDR_WIDTH-1:0] wr_beg_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] wr_end_addr,
    input  logic [LEN_WIDTH-1:0]      wr_burst_len,
    input  logic                      wr_addr_clr,
    input  logic [CNT_WIDTH-1:0]      wr_fifo_cnt,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_beg_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_end_addr,
    input  logic [LEN_WIDTH-1:0]      rd_burst_len,
    input  logic                      rd_mem_enable,
    input  logic [CNT_WIDTH-1:0]      rd_fifo_space,
    output logic                      wr_req,
    input  logic                      wr_ack,
    input  logic                      wr_done,
    output logic [AXI_ADDR_WIDTH-1:0] wr_addr,
    output logic [LEN_WIDTH-1:0]      wr_len,
    output logic                      wr_wrap,
    output logic                      rd_req,
    input  logic                      rd_ack,
    input  logic                      rd_done,
    output logic [AXI_ADDR_WIDTH-1:0] rd_addr,
    output logic [LEN_WIDTH-1:0]      rd_len,
    output logic                      rd_wrap,
    output logic                      busy,
    output logic [2:0]                dbg_state
);

    // Handshake: *_req rises the cycle after a grant and holds, with *_addr/*_len stable,
    // until the master pulses *_ack; *_done closes the burst. Pulses outside the matching
    // state are ignored; ack+done together in *_REQ complete the burst at once.
    localparam int CW1 = CNT_WIDTH + 1;

    arb_state_e state;
    grant_e     last_grant;
    logic       wr_ok, rd_ok;
    logic       wr_adv, rd_adv;
    logic       idle;

    assign idle  = (state == IDLE);
    assign wr_ok = calib_done && !wr_addr_clr &&
                   ({1'b0, wr_fifo_cnt} >= (CW1'(wr_burst_len) + CW1'(1)));
    assign rd_ok = calib_done && rd_mem_enable &&
                   ({1'b0, rd_fifo_space} >= (CW1'(rd_burst_len) + CW1'(1)));

    assign wr_adv = wr_done && ((state == WR_BUSY) || (state == WR_REQ && wr_ack));
    assign rd_adv = rd_done && ((state == RD_BUSY) || (state == RD_REQ && rd_ack));

    assign wr_req    = (state == WR_REQ);
    assign rd_req    = (state == RD_REQ);
    assign busy      = !idle;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_RD;
            wr_len     <= '0;
            rd_len     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ok && (!rd_ok || last_grant == GNT_RD)) begin
                        state      <= WR_REQ;
                        last_grant <= GNT_WR;
                        wr_len     <= wr_burst_len;
                    end else if (rd_ok) begin
                        state      <= RD_REQ;
                        last_grant <= GNT_RD;
                        rd_len     <= rd_burst_len;
                    end
                end
                WR_REQ:  if (wr_ack)  state <= wr_done ? IDLE : WR_BUSY;
                WR_BUSY: if (wr_done) state <= IDLE;
                RD_REQ:  if (rd_ack)  state <= rd_done ? IDLE : RD_BUSY;
                RD_BUSY: if (rd_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    ddr_addr_gen #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .LEN_WIDTH      (LEN_WIDTH)
    ) u_wr_addr (
        .clk      (clk),
        .rst      (rst),
        .idle     (idle),
        .clr      (wr_addr_clr),
        .advance  (wr_adv),
        .beg_addr (wr_beg_addr),
        .end_addr (wr_end_addr),
        .len      (wr_len),
        .addr     (wr_addr),
        .wrap     (wr_wrap)
    );

    ddr_addr_gen #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .LEN_WIDTH      (LEN_WIDTH)
    ) u_rd_addr (
        .clk      (clk),
        .rst      (rst),
        .idle     (idle),
        .clr      (!rd_mem_enable),
        .advance  (rd_adv),
        .beg_addr (rd_beg_addr),
        .end_addr (rd_end_addr),
        .len      (rd_len),
        .addr     (rd_addr),
        .wrap     (rd_wrap)
    );

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Bench for ddr_rw_arbiter: a responder plays both AXI masters; expected grant order,
// start addresses and wrap pulses are queued when stimulus is set up and popped per grant.
module tb_ddr_rw_arbiter;

    localparam int AW = 30;
    localparam int LW = 8;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          calib_done;
    logic [AW-1:0] wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr;
    logic [LW-1:0] wr_burst_len, rd_burst_len;
    logic          wr_addr_clr, rd_mem_enable;
    logic [CW-1:0] wr_fifo_cnt, rd_fifo_space;
    logic          wr_req, rd_req, wr_ack, rd_ack, wr_done, rd_done;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [LW-1:0] wr_len, rd_len;
    logic          wr_wrap, rd_wrap, busy;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: one entry per expected grant (0 = write, 1 = read).
    logic          exp_gnt_q[$];
    logic [AW-1:0] exp_q[$];
    logic          exp_wrap_q[$];

    always #5 clk = ~clk;

    ddr_rw_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .calib_done    (calib_done),
        .wr_beg_addr   (wr_beg_addr),
        .wr_end_addr   (wr_end_addr),
        .wr_burst_len  (wr_burst_len),
        .wr_addr_clr   (wr_addr_clr),
        .wr_fifo_cnt   (wr_fifo_cnt),
        .rd_beg_addr   (rd_beg_addr),
        .rd_end_addr   (rd_end_addr),
        .rd_burst_len  (rd_burst_len),
        .rd_mem_enable (rd_mem_enable),
        .rd_fifo_space (rd_fifo_space),
        .wr_req        (wr_req),
        .wr_ack        (wr_ack),
        .wr_done       (wr_done),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .wr_wrap       (wr_wrap),
        .rd_req        (rd_req),
        .rd_ack        (rd_ack),
        .rd_done       (rd_done),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_wrap       (rd_wrap),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    task automatic push_exp(input logic gnt, input logic [AW-1:0] a, input logic w);
        exp_gnt_q.push_back(gnt);
        exp_q.push_back(a);
        exp_wrap_q.push_back(w);
    endtask

    // Wait for a grant, check it against the scoreboard, then ack and finish the burst.
    task automatic serve_one(input logic same_cycle);
        int            t;
        logic          side;
        logic          eg, ew;
        logic [AW-1:0] ea, got_addr;
        logic [LW-1:0] got_len;
        t = 0;
        while (!wr_req && !rd_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!wr_req && !rd_req) begin
            n_fail++;
            $display("FAIL req_timeout: no request after %0d cycles", t);
            return;
        end
        n_checks++;
        if (exp_gnt_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: unexpected grant wr_req=%0b rd_req=%0b", wr_req, rd_req);
            return;
        end
        side     = rd_req;
        eg       = exp_gnt_q.pop_front();
        ea       = exp_q.pop_front();
        ew       = exp_wrap_q.pop_front();
        got_addr = side ? rd_addr : wr_addr;
        got_len  = side ? rd_len : wr_len;
        n_checks++;
        if (side !== eg) begin
            n_fail++;
            $display("FAIL grant_side: got %0d expected %0d (0=wr 1=rd)", side, eg);
        end
        n_checks++;
        if (got_addr !== ea) begin
            n_fail++;
            $display("FAIL grant_addr: got %0d expected %0d", got_addr, ea);
        end
        n_checks++;
        if (got_len !== 8'd31) begin
            n_fail++;
            $display("FAIL grant_len: got %0d expected 31", got_len);
        end
        if (side) rd_ack = 1'b1; else wr_ack = 1'b1;
        if (same_cycle) begin
            if (side) rd_done = 1'b1; else wr_done = 1'b1;
        end
        @(negedge clk);
        wr_ack = 1'b0; rd_ack = 1'b0;
        if (!same_cycle) begin
            wr_done = 1'b0; rd_done = 1'b0;
            repeat (2) @(negedge clk);
            if (side) rd_done = 1'b1; else wr_done = 1'b1;
            @(negedge clk);
        end
        wr_done = 1'b0; rd_done = 1'b0;
        n_checks++;
        if ((side ? rd_wrap : wr_wrap) !== ew) begin
            n_fail++;
            $display("FAIL wrap_pulse: got %0b expected %0b at addr %0d", side ? rd_wrap : wr_wrap, ew, ea);
        end
        n_checks++;
        if (wr_req !== 1'b0 || rd_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: wr_req=%0b rd_req=%0b busy=%0b expected all 0", wr_req, rd_req, busy);
        end
        if (ew) begin
            @(negedge clk);
            n_checks++;
            if ((side ? rd_wrap : wr_wrap) !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_width: wrap still %0b one cycle later, expected 0", side ? rd_wrap : wr_wrap);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; calib_done = 1'b0;
        wr_beg_addr = 30'd0;    wr_end_addr = 30'd767;  wr_burst_len = 8'd31;
        rd_beg_addr = 30'd4096; rd_end_addr = 30'd5119; rd_burst_len = 8'd31;
        wr_addr_clr = 1'b0; rd_mem_enable = 1'b0;
        wr_fifo_cnt = 10'd64; rd_fifo_space = 10'd0;
        wr_ack = 1'b0; rd_ack = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (wr_req !== 1'b0 || rd_req !== 1'b0 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: wr_req=%0b rd_req=%0b busy=%0b state=%0d expected 0/0/0/0",
                     wr_req, rd_req, busy, dbg_state);
        end
        n_checks++;
        if (wr_addr !== 30'd0 || rd_addr !== 30'd4096) begin
            n_fail++;
            $display("FAIL reset_addr: wr_addr=%0d rd_addr=%0d expected 0/4096", wr_addr, rd_addr);
        end
        n_checks++;
        if (wr_len !== 8'd0 || rd_len !== 8'd0 || wr_wrap !== 1'b0 || rd_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_len_wrap: wr_len=%0d rd_len=%0d wr_wrap=%0b rd_wrap=%0b expected 0",
                     wr_len, rd_len, wr_wrap, rd_wrap);
        end
        calib_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wr_req !== 1'b1 || wr_len !== 8'd31) begin
            n_fail++;
            $display("FAIL calib_grant: wr_req=%0b wr_len=%0d expected 1/31", wr_req, wr_len);
        end
        push_exp(1'b0, 30'd0, 1'b0);
    endtask

    task automatic test_round_robin();
        rd_mem_enable = 1'b1;
        rd_fifo_space = 10'd64;
        push_exp(1'b1, 30'd4096, 1'b0);
        push_exp(1'b0, 30'd256,  1'b0);
        push_exp(1'b1, 30'd4352, 1'b0);
        push_exp(1'b0, 30'd512,  1'b1);
        push_exp(1'b1, 30'd4608, 1'b0);
        push_exp(1'b0, 30'd0,    1'b0);
        repeat (7) serve_one(1'b0);
    endtask

    task automatic test_ack_done_same();
        push_exp(1'b1, 30'd4864, 1'b1);
        serve_one(1'b1);
        n_checks++;
        if (rd_addr !== 30'd4096) begin
            n_fail++;
            $display("FAIL same_cycle_addr: rd_addr=%0d expected 4096", rd_addr);
        end
    endtask

    task automatic test_rd_disable();
        int   t;
        logic seen;
        push_exp(1'b0, 30'd256, 1'b0);
        serve_one(1'b0);
        t = 0;
        while (!rd_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rd_req !== 1'b1 || rd_addr !== 30'd4096) begin
            n_fail++;
            $display("FAIL rd_dis_grant: rd_req=%0b rd_addr=%0d expected 1/4096", rd_req, rd_addr);
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        rd_mem_enable = 1'b0;
        wr_fifo_cnt = 10'd0;
        repeat (2) @(negedge clk);
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        n_checks++;
        if (rd_addr !== 30'd4096 || rd_wrap !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_dis_done: rd_addr=%0d rd_wrap=%0b busy=%0b expected 4096/0/0",
                     rd_addr, rd_wrap, busy);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rd_req || wr_req) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_dis_quiet: request seen=%0b expected 0", seen);
        end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        wr_fifo_cnt = 10'd64;
        t = 0;
        while (!wr_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (wr_req !== 1'b1 || wr_addr !== 30'd512) begin
            n_fail++;
            $display("FAIL rst_mid_grant: wr_req=%0b wr_addr=%0d expected 1/512", wr_req, wr_addr);
        end
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || dbg_state !== 3'd2) begin
            n_fail++;
            $display("FAIL rst_mid_busy: busy=%0b state=%0d expected 1/2", busy, dbg_state);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr_fifo_cnt = 10'd0;
        n_checks++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || wr_addr !== 30'd0 || wr_len !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid_state: wr_req=%0b busy=%0b wr_addr=%0d wr_len=%0d expected 0/0/0/0",
                     wr_req, busy, wr_addr, wr_len);
        end
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || wr_addr !== 30'd0 || wr_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL late_done: busy=%0b wr_addr=%0d wr_wrap=%0b expected 0/0/0", busy, wr_addr, wr_wrap);
        end
    endtask

    task automatic test_threshold();
        logic seen;
        wr_fifo_cnt = 10'd31;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wr_req) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL thresh_below: wr_req seen=%0b with cnt 31, expected 0", seen);
        end
        wr_fifo_cnt = 10'd32;
        @(negedge clk);
        n_checks++;
        if (wr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL thresh_exact: wr_req=%0b with cnt 32, expected 1", wr_req);
        end
        push_exp(1'b0, 30'd0, 1'b0);
        wr_fifo_cnt = 10'd0;
        serve_one(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_ack_done_same();
        test_rd_disable();
        test_reset_mid_burst();
        test_threshold();
        n_checks++;
        if (exp_gnt_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d expected grants never seen, expected 0", exp_gnt_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
